traffic_input_sequencer: RTL and testbench



---
 rtl/traffic_pkg.sv | 30 +++
 rtl/input_debouncer.sv | 55 +++++
 rtl/traffic_input_sequencer.sv | 137 +++++++++++++
 tb/tb_traffic_input_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light controller and its input sequencer:
// walk FSM encodings, default timing constants and the light-state encodings.
package traffic_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_PEND = 2'd1,
    W_LOCK = 2'd2
  } walk_state_t;

  typedef enum logic [2:0] {
    L_NS_GREEN  = 3'd0,
    L_NS_YELLOW = 3'd1,
    L_EW_GREEN  = 3'd2,
    L_EW_YELLOW = 3'd3,
    L_ALL_RED   = 3'd4,
    L_WALK      = 3'd5
  } light_state_t;

  localparam int DEF_TICK_DIV      = 100000000;
  localparam int DEF_DEB_CYCLES    = 2000000;
  localparam int DEF_SENSOR_QUAL   = 2;
  localparam int DEF_LOCKOUT_TICKS = 3;

  // Bits needed to hold values 0..max_val; never narrower than one bit.
  function automatic int width_for(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchronizer followed by a consecutive-mismatch debouncer for one
// raw asynchronous input.
module input_debouncer
  import traffic_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic master_clock,
  input  logic reset,
  input  logic raw,
  output logic deb
);

  localparam int DW = width_for(DEB_CYCLES - 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [DW-1:0] DEB_ONE  = DW'(1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          deb_reg;
  logic          deb_next;
  logic [DW-1:0] mis_cnt_reg;
  logic [DW-1:0] mis_cnt_next;

  // Any matching cycle restarts the count, so only an unbroken run of
  // DEB_CYCLES mismatches moves the debounced value.
  always_comb begin
    deb_next     = deb_reg;
    mis_cnt_next = '0;
    if (sync2_reg != deb_reg) begin
      if (mis_cnt_reg == DEB_LAST) begin
        deb_next = sync2_reg;
      end else begin
        mis_cnt_next = mis_cnt_reg + DEB_ONE;
      end
    end
  end

  always_ff @(posedge master_clock) begin
    if (reset) begin
      sync1_reg   <= 1'b0;
      sync2_reg   <= 1'b0;
      deb_reg     <= 1'b0;
      mis_cnt_reg <= '0;
    end else begin
      sync1_reg   <= raw;
      sync2_reg   <= sync1_reg;
      deb_reg     <= deb_next;
      mis_cnt_reg <= mis_cnt_next;
    end
  end

  assign deb = deb_reg;

endmodule

// File: rtl/traffic_input_sequencer.sv
// Front end of the traffic light FSM: tick generation, input conditioning,
// pedestrian request handshake with post-service lockout, sensor qualification.
module traffic_input_sequencer
  import traffic_pkg::*;
#(
  parameter int TICK_DIV      = DEF_TICK_DIV,
  parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int SENSOR_QUAL   = DEF_SENSOR_QUAL,
  parameter int LOCKOUT_TICKS = DEF_LOCKOUT_TICKS
) (
  input  logic master_clock,
  input  logic reset,
  input  logic walk_btn,
  input  logic sensor_raw,
  input  logic walk_ack,
  output logic sec_tick,
  output logic half_tick,
  output logic walk_req,
  output logic sensor_q,
  output logic lockout
);

  localparam int TW = width_for(TICK_DIV - 1);
  localparam int LW = width_for(LOCKOUT_TICKS);
  localparam int QW = width_for(SENSOR_QUAL);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(TICK_DIV / 2 - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);
  localparam logic [LW-1:0] LOCK_INIT = LW'(LOCKOUT_TICKS);
  localparam logic [LW-1:0] LOCK_ONE  = LW'(1);
  localparam logic [QW-1:0] QUAL_MAX  = QW'(SENSOR_QUAL);
  localparam logic [QW-1:0] QUAL_ONE  = QW'(1);

  logic [TW-1:0] tick_cnt_reg;
  logic [TW-1:0] tick_cnt_next;
  logic [1:0]    raw_vec;
  logic [1:0]    deb_vec;
  logic          walk_deb_d_reg;
  logic          walk_edge;
  walk_state_t   state_reg;
  walk_state_t   state_next;
  logic [LW-1:0] lock_cnt_reg;
  logic [LW-1:0] lock_cnt_next;
  logic [QW-1:0] qual_cnt_reg;
  logic [QW-1:0] qual_cnt_next;
  logic          walk_req_reg;
  logic          lockout_reg;

  assign tick_cnt_next = (tick_cnt_reg == TICK_LAST) ? '0 : tick_cnt_reg + TICK_ONE;
  assign sec_tick      = (tick_cnt_reg == TICK_LAST);
  assign half_tick     = (tick_cnt_reg == HALF_LAST) || sec_tick;

  // Bit 0 carries the walk button, bit 1 the side-street sensor.
  assign raw_vec = {sensor_raw, walk_btn};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_deb
      input_debouncer #(
        .DEB_CYCLES (DEB_CYCLES)
      ) u_deb (
        .master_clock (master_clock),
        .reset        (reset),
        .raw          (raw_vec[gi]),
        .deb          (deb_vec[gi])
      );
    end
  endgenerate

  assign walk_edge = deb_vec[0] & ~walk_deb_d_reg;

  // Edges outside W_IDLE are dropped; an ack in W_PEND wins over a
  // coincident edge.
  always_comb begin
    state_next    = state_reg;
    lock_cnt_next = lock_cnt_reg;
    case (state_reg)
      W_IDLE: begin
        if (walk_edge) begin
          state_next = W_PEND;
        end
      end
      W_PEND: begin
        if (walk_ack) begin
          state_next    = W_LOCK;
          lock_cnt_next = LOCK_INIT;
        end
      end
      W_LOCK: begin
        if (lock_cnt_reg == '0) begin
          state_next = W_IDLE;
        end else if (sec_tick) begin
          lock_cnt_next = lock_cnt_reg - LOCK_ONE;
        end
      end
      default: begin
        state_next    = W_IDLE;
        lock_cnt_next = '0;
      end
    endcase
  end

  always_comb begin
    qual_cnt_next = qual_cnt_reg;
    if (!deb_vec[1]) begin
      qual_cnt_next = '0;
    end else if (sec_tick && (qual_cnt_reg != QUAL_MAX)) begin
      qual_cnt_next = qual_cnt_reg + QUAL_ONE;
    end
  end

  always_ff @(posedge master_clock) begin
    if (reset) begin
      tick_cnt_reg   <= '0;
      walk_deb_d_reg <= 1'b0;
      state_reg      <= W_IDLE;
      lock_cnt_reg   <= '0;
      qual_cnt_reg   <= '0;
      walk_req_reg   <= 1'b0;
      lockout_reg    <= 1'b0;
    end else begin
      tick_cnt_reg   <= tick_cnt_next;
      walk_deb_d_reg <= deb_vec[0];
      state_reg      <= state_next;
      lock_cnt_reg   <= lock_cnt_next;
      qual_cnt_reg   <= qual_cnt_next;
      walk_req_reg   <= (state_reg == W_PEND);
      lockout_reg    <= (state_reg == W_LOCK);
    end
  end

  assign walk_req = walk_req_reg;
  assign lockout  = lockout_reg;
  assign sensor_q = (qual_cnt_reg == QUAL_MAX);

endmodule

// File: tb/tb_traffic_input_sequencer.sv
// Directed bench for traffic_input_sequencer: expectations are queued with the
// cycle they fall due and compared on the falling edge of that cycle.
module tb_traffic_input_sequencer;

  localparam int SIG_SEC  = 0;
  localparam int SIG_HALF = 1;
  localparam int SIG_REQ  = 2;
  localparam int SIG_SQ   = 3;
  localparam int SIG_LOCK = 4;

  typedef struct {
    int    due;
    int    sig;
    logic  val;
    string tag;
  } exp_t;

  logic master_clock;
  logic reset;
  logic walk_btn;
  logic sensor_raw;
  logic walk_ack;
  logic sec_tick;
  logic half_tick;
  logic walk_req;
  logic sensor_q;
  logic lockout;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  traffic_input_sequencer #(
    .TICK_DIV      (10),
    .DEB_CYCLES    (4),
    .SENSOR_QUAL   (2),
    .LOCKOUT_TICKS (3)
  ) dut (
    .master_clock (master_clock),
    .reset        (reset),
    .walk_btn     (walk_btn),
    .sensor_raw   (sensor_raw),
    .walk_ack     (walk_ack),
    .sec_tick     (sec_tick),
    .half_tick    (half_tick),
    .walk_req     (walk_req),
    .sensor_q     (sensor_q),
    .lockout      (lockout)
  );

  initial master_clock = 1'b0;
  always #5 master_clock = ~master_clock;

  // cyc == k between rising edge k and rising edge k+1.
  always @(posedge master_clock) cyc <= cyc + 1;

  function automatic logic observe(input int sig);
    case (sig)
      SIG_SEC:  return sec_tick;
      SIG_HALF: return half_tick;
      SIG_REQ:  return walk_req;
      SIG_SQ:   return sensor_q;
      SIG_LOCK: return lockout;
      default:  return 1'bx;
    endcase
  endfunction

  task automatic push_exp(input int due, input int sig, input logic v, input string tag);
    exp_t e;
    e.due = due;
    e.sig = sig;
    e.val = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic push_all_zero(input int due, input string tag);
    for (int s = 0; s < 5; s++) push_exp(due, s, 1'b0, tag);
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge master_clock);
      #1;
    end
  endtask

  always @(negedge master_clock) begin
    logic obs;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        obs = observe(sb[i].sig);
        checks++;
        assert (obs === sb[i].val) else begin
          errors++;
          $error("FAIL %s sig=%0d cyc=%0d observed=%b expected=%b",
                 sb[i].tag, sb[i].sig, cyc, obs, sb[i].val);
        end
        $display("check %-12s sig=%0d cyc=%0d observed=%b expected=%b",
                 sb[i].tag, sb[i].sig, cyc, obs, sb[i].val);
        sb.delete(i);
      end
    end
  end

  initial begin
    reset      = 1'b1;
    walk_btn   = 1'b0;
    sensor_raw = 1'b0;
    walk_ack   = 1'b0;

    // Reset state, then release: tick counter is 0 during cycle 3.
    goto(3);
    push_all_zero(3, "in_reset");
    push_exp(6,  SIG_HALF, 1'b0, "half_pre");
    push_exp(7,  SIG_HALF, 1'b1, "half_first");
    push_exp(7,  SIG_SEC,  1'b0, "sec_at_half");
    push_exp(8,  SIG_HALF, 1'b0, "half_post");
    push_exp(11, SIG_SEC,  1'b0, "sec_pre");
    push_exp(12, SIG_SEC,  1'b1, "sec_first");
    push_exp(12, SIG_HALF, 1'b1, "half_at_sec");
    push_exp(13, SIG_SEC,  1'b0, "sec_post");
    push_exp(17, SIG_HALF, 1'b1, "half_third");
    push_exp(17, SIG_SEC,  1'b0, "sec_mid");
    push_exp(22, SIG_SEC,  1'b1, "sec_second");
    reset = 1'b0;

    // Three-cycle glitch must not reach walk_req.
    goto(25);
    walk_btn = 1'b1;
    push_exp(35, SIG_REQ, 1'b0, "glitch_a");
    push_exp(40, SIG_REQ, 1'b0, "glitch_b");
    goto(28);
    walk_btn = 1'b0;

    // Held press: first sampled at edge 46, walk_req at 46+7.
    goto(45);
    walk_btn = 1'b1;
    push_exp(52, SIG_REQ, 1'b0, "press_early");
    push_exp(53, SIG_REQ, 1'b1, "press_req");
    push_exp(75, SIG_REQ, 1'b1, "req_held");
    push_exp(80, SIG_LOCK, 1'b0, "pend_nolock");
    goto(65);
    walk_btn = 1'b0;

    // Ack sampled at edge 81; lockout counts ticks at edges 83, 93, 103.
    goto(80);
    walk_ack = 1'b1;
    push_exp(82,  SIG_REQ,  1'b0, "ack_req");
    push_exp(82,  SIG_LOCK, 1'b1, "ack_lock");
    push_exp(104, SIG_LOCK, 1'b1, "lock_hold");
    push_exp(105, SIG_LOCK, 1'b0, "lock_end");
    push_exp(110, SIG_REQ,  1'b0, "lock_drop");
    goto(81);
    walk_ack = 1'b0;
    goto(84);
    walk_btn = 1'b1;
    goto(94);
    walk_btn = 1'b0;

    // Fresh press after lockout.
    goto(110);
    walk_btn = 1'b1;
    push_exp(117, SIG_REQ, 1'b0, "press2_early");
    push_exp(118, SIG_REQ, 1'b1, "press2_req");
    goto(125);
    walk_btn = 1'b0;

    // New debounced edge lands on edge 147 together with walk_ack.
    goto(140);
    walk_btn = 1'b1;
    goto(146);
    walk_ack = 1'b1;
    push_exp(148, SIG_REQ,  1'b0, "coinc_req");
    push_exp(148, SIG_LOCK, 1'b1, "coinc_lock");
    push_exp(174, SIG_LOCK, 1'b1, "coinc_hold");
    push_exp(176, SIG_LOCK, 1'b0, "coinc_end");
    push_exp(176, SIG_REQ,  1'b0, "coinc_drop");
    goto(147);
    walk_ack = 1'b0;
    goto(150);
    walk_btn = 1'b0;

    // walk_ack in W_IDLE is ignored.
    goto(180);
    walk_ack = 1'b1;
    push_exp(183, SIG_REQ,  1'b0, "idle_ack_req");
    push_exp(183, SIG_LOCK, 1'b0, "idle_ack_lk");
    goto(181);
    walk_ack = 1'b0;

    // Sensor debounced high after edge 196; ticks counted at edges 203, 213.
    goto(190);
    sensor_raw = 1'b1;
    push_exp(203, SIG_SQ, 1'b0, "sq_one_tick");
    push_exp(212, SIG_SQ, 1'b0, "sq_pre");
    push_exp(213, SIG_SQ, 1'b1, "sq_on");
    push_exp(220, SIG_SQ, 1'b1, "sq_hold");
    // Five low samples debounce to 0 after edge 231; sensor_q clears at 232.
    goto(225);
    sensor_raw = 1'b0;
    push_exp(231, SIG_SQ, 1'b1, "sq_before_clr");
    push_exp(232, SIG_SQ, 1'b0, "sq_clear");
    goto(230);
    sensor_raw = 1'b1;

    // Reach W_PEND while the qualifier sits at 1, then reset.
    goto(235);
    walk_btn = 1'b1;
    push_exp(245, SIG_REQ, 1'b1, "pre_rst_req");
    push_exp(245, SIG_SQ,  1'b0, "pre_rst_sq");
    goto(246);
    reset    = 1'b1;
    walk_btn = 1'b0;
    push_all_zero(247, "mid_reset");
    goto(247);
    reset = 1'b0;
    push_exp(251, SIG_HALF, 1'b1, "rst_half");
    push_exp(255, SIG_SEC,  1'b0, "rst_sec_pre");
    push_exp(256, SIG_SEC,  1'b1, "rst_sec");
    push_exp(260, SIG_REQ,  1'b0, "rst_req_lost");
    push_exp(260, SIG_SQ,   1'b0, "rst_sq");
    push_exp(266, SIG_SQ,   1'b0, "rst_sq_pre");
    push_exp(267, SIG_SQ,   1'b1, "rst_sq_on");

    goto(275);
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0 pending", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
